// File: rtl/riscv_pkg.sv
// Shared RV32 core constants: register-file geometry, named register
// indices and the default integer data path width.
package riscv_pkg;

   localparam int unsigned XLEN_DEFAULT         = 32;
   localparam int unsigned REGISTER_COUNT       = 32;
   localparam int unsigned REGISTER_INDEX_WIDTH = $clog2(REGISTER_COUNT);

   typedef logic [REGISTER_INDEX_WIDTH-1:0] reg_idx_t;

   // Named architectural register indices (ABI aliases in comments)
   localparam reg_idx_t X0 = reg_idx_t'(0);   // zero
   localparam reg_idx_t X1 = reg_idx_t'(1);   // ra
   localparam reg_idx_t X2 = reg_idx_t'(2);   // sp
   localparam reg_idx_t X3 = reg_idx_t'(3);   // gp
   localparam reg_idx_t X4 = reg_idx_t'(4);   // tp
   localparam reg_idx_t X5 = reg_idx_t'(5);   // t0

endpackage

// File: rtl/regfile_read_port.sv
// Combinational register-file read port: selects one entry by index and
// forces the result to zero when the index is x0.
// Ports:
//   addr_i : register index to read
//   regs_i : full register array
//   data_o : selected register contents (zero for x0), combinational
module regfile_read_port
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEFAULT
) (
   input  logic [REGISTER_INDEX_WIDTH-1:0] addr_i,
   input  logic [XLEN-1:0]                 regs_i [REGISTER_COUNT],
   output logic [XLEN-1:0]                 data_o
);

   // x0 guard keeps reads at zero independent of what entry 0 holds
   assign data_o = (addr_i == X0) ? '0 : regs_i[addr_i];

endmodule

// File: rtl/regfile.sv
// RV32 integer register file: 32 x XLEN flip-flop storage, two
// combinational read ports and one synchronous write port. x0 reads as
// zero and is never written. No write-to-read bypass: a same-cycle read of
// the register being written returns the pre-edge value.
// Ports:
//   clk       : clock, all state updates on rising edge
//   n_rst     : asynchronous reset, active-high, clears every register
//   rs1_addr  : read port 1 index       rs1_data : read port 1 data
//   rs2_addr  : read port 2 index       rs2_data : read port 2 data
//   rd_addr   : write index
//   rd_wen    : write enable
//   rd_wdata  : write data
module regfile
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEFAULT
) (
   input  logic                            clk,
   input  logic                            n_rst,
   input  logic [REGISTER_INDEX_WIDTH-1:0] rs1_addr,
   input  logic [REGISTER_INDEX_WIDTH-1:0] rs2_addr,
   input  logic [REGISTER_INDEX_WIDTH-1:0] rd_addr,
   input  logic                            rd_wen,
   input  logic [XLEN-1:0]                 rd_wdata,
   output logic [XLEN-1:0]                 rs1_data,
   output logic [XLEN-1:0]                 rs2_data
);

   logic [XLEN-1:0] regs_q [REGISTER_COUNT];
   logic [XLEN-1:0] regs_d [REGISTER_COUNT];

   // Write decode; writes to x0 are dropped so entry 0 stays at its reset zero
   always_comb begin
      regs_d = regs_q;
      if (rd_wen && (rd_addr != X0)) begin
         regs_d[rd_addr] = rd_wdata;
      end
   end

   // Storage; the reset name is historical, the reset itself is active-high
   always_ff @(posedge clk or posedge n_rst) begin
      if (n_rst) begin
         for (int i = 0; i < int'(REGISTER_COUNT); i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   regfile_read_port #(.XLEN(XLEN)) u_rs1_port (
      .addr_i (rs1_addr),
      .regs_i (regs_q),
      .data_o (rs1_data)
   );

   regfile_read_port #(.XLEN(XLEN)) u_rs2_port (
      .addr_i (rs2_addr),
      .regs_i (regs_q),
      .data_o (rs2_data)
   );

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile: reset, x0 hardwiring, basic
// write/read, write-enable gating, no-bypass timing, back-to-back writes,
// a seeded random smoke run and mid-sequence asynchronous reset.
module tb_regfile;

   logic        clk;
   logic        n_rst;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [4:0]  rd_addr;
   logic        rd_wen;
   logic [31:0] rd_wdata;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;

   int checks = 0;
   int errors = 0;

   logic [31:0] model [32];

   regfile #(.XLEN(32)) dut (
      .clk      (clk),
      .n_rst    (n_rst),
      .rs1_addr (rs1_addr),
      .rs2_addr (rs2_addr),
      .rd_addr  (rd_addr),
      .rd_wen   (rd_wen),
      .rd_wdata (rd_wdata),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_write(input logic [4:0] a, input logic [31:0] d);
      rd_addr  = a;
      rd_wdata = d;
      rd_wen   = 1'b1;
      @(posedge clk);
      #1;
      rd_wen   = 1'b0;
   endtask

   task automatic test_reset;
      n_rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_rst = 1'b0;
      for (int i = 0; i < 32; i++) begin
         rs1_addr = 5'(i);
         rs2_addr = 5'(31 - i);
         #1;
         checks++;
         if (rs1_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_rs1 idx=%0d got=%h exp=%h", i, rs1_data, 32'h0);
         end
         checks++;
         if (rs2_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_rs2 idx=%0d got=%h exp=%h", 31 - i, rs2_data, 32'h0);
         end
      end
   endtask

   task automatic test_x0;
      do_write(5'd0, 32'hFFFF_FFFF);
      rs1_addr = 5'd0;
      rs2_addr = 5'd0;
      #1;
      checks++;
      if (rs1_data !== 32'h0) begin
         errors++;
         $display("FAIL x0_rs1 got=%h exp=%h", rs1_data, 32'h0);
      end
      checks++;
      if (rs2_data !== 32'h0) begin
         errors++;
         $display("FAIL x0_rs2 got=%h exp=%h", rs2_data, 32'h0);
      end
   endtask

   task automatic test_basic;
      do_write(5'd1, 32'h1234_5678);
      do_write(5'd2, 32'hDEAD_BEEF);
      rs1_addr = 5'd1;
      rs2_addr = 5'd2;
      #1;
      checks++;
      if (rs1_data !== 32'h1234_5678) begin
         errors++;
         $display("FAIL basic_x1 got=%h exp=%h", rs1_data, 32'h1234_5678);
      end
      checks++;
      if (rs2_data !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL basic_x2 got=%h exp=%h", rs2_data, 32'hDEAD_BEEF);
      end
      // both ports on the same register
      rs1_addr = 5'd2;
      #1;
      checks++;
      if (rs1_data !== 32'hDEAD_BEEF || rs2_data !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL same_reg got=%h/%h exp=%h", rs1_data, rs2_data, 32'hDEAD_BEEF);
      end
   endtask

   task automatic test_wen_gating;
      rd_addr  = 5'd3;
      rd_wdata = 32'h1111_1111;
      rd_wen   = 1'b0;
      @(posedge clk);
      #1;
      rs1_addr = 5'd3;
      #1;
      checks++;
      if (rs1_data !== 32'h0) begin
         errors++;
         $display("FAIL wen_gating got=%h exp=%h", rs1_data, 32'h0);
      end
   endtask

   task automatic test_no_bypass;
      do_write(5'd5, 32'hAAAA_0001);
      rd_addr  = 5'd5;
      rd_wdata = 32'hBBBB_0002;
      rd_wen   = 1'b1;
      rs1_addr = 5'd5;
      #1;
      checks++;
      if (rs1_data !== 32'hAAAA_0001) begin
         errors++;
         $display("FAIL no_bypass_pre got=%h exp=%h", rs1_data, 32'hAAAA_0001);
      end
      @(posedge clk);
      #1;
      rd_wen = 1'b0;
      checks++;
      if (rs1_data !== 32'hBBBB_0002) begin
         errors++;
         $display("FAIL no_bypass_post got=%h exp=%h", rs1_data, 32'hBBBB_0002);
      end
   endtask

   task automatic test_back_to_back;
      rs2_addr = 5'd6;
      rd_addr  = 5'd6;
      rd_wen   = 1'b1;
      rd_wdata = 32'h0000_0A01;
      @(posedge clk);
      #1;
      checks++;
      if (rs2_data !== 32'h0000_0A01) begin
         errors++;
         $display("FAIL b2b_first got=%h exp=%h", rs2_data, 32'h0000_0A01);
      end
      rd_wdata = 32'h0000_0A02;
      @(posedge clk);
      #1;
      rd_wdata = 32'h0000_0A03;
      @(posedge clk);
      #1;
      rd_wen = 1'b0;
      checks++;
      if (rs2_data !== 32'h0000_0A03) begin
         errors++;
         $display("FAIL b2b_last got=%h exp=%h", rs2_data, 32'h0000_0A03);
      end
   endtask

   task automatic test_random;
      logic [4:0]  a;
      logic [31:0] d;
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      model[1] = 32'h1234_5678;
      model[2] = 32'hDEAD_BEEF;
      model[5] = 32'hBBBB_0002;
      model[6] = 32'h0000_0A03;
      for (int i = 0; i < 200; i++) begin
         a = 5'($urandom_range(31, 1));
         d = $urandom;
         do_write(a, d);
         model[a] = d;
         rs1_addr = 5'($urandom_range(31, 1));
         rs2_addr = 5'd0;
         #1;
         checks++;
         if (rs1_data !== model[rs1_addr]) begin
            errors++;
            $display("FAIL random_rs1 iter=%0d idx=%0d got=%h exp=%h",
                     i, rs1_addr, rs1_data, model[rs1_addr]);
         end
         checks++;
         if (rs2_data !== 32'h0) begin
            errors++;
            $display("FAIL random_rs2 iter=%0d got=%h exp=%h", i, rs2_data, 32'h0);
         end
      end
   endtask

   task automatic test_reset_mid;
      // assert reset mid-cycle with a write pending; clearing must be immediate
      @(negedge clk);
      rd_addr  = 5'd7;
      rd_wdata = 32'h7777_7777;
      rd_wen   = 1'b1;
      #1;
      n_rst = 1'b1;
      #1;
      for (int i = 0; i < 32; i++) begin
         rs1_addr = 5'(i);
         rs2_addr = 5'(i);
         #0.5;
         checks++;
         if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid idx=%0d got=%h/%h exp=%h", i, rs1_data, rs2_data, 32'h0);
         end
      end
      // a write held across an edge under reset is ignored
      @(posedge clk);
      #1;
      rs1_addr = 5'd7;
      #1;
      checks++;
      if (rs1_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_write_ignored got=%h exp=%h", rs1_data, 32'h0);
      end
      n_rst  = 1'b0;
      rd_wen = 1'b0;
      do_write(5'd7, 32'hCAFE_F00D);
      rs2_addr = 5'd7;
      #1;
      checks++;
      if (rs2_data !== 32'hCAFE_F00D) begin
         errors++;
         $display("FAIL post_reset_write got=%h exp=%h", rs2_data, 32'hCAFE_F00D);
      end
   endtask

   initial begin
      n_rst    = 1'b1;
      rs1_addr = 5'd0;
      rs2_addr = 5'd0;
      rd_addr  = 5'd0;
      rd_wen   = 1'b0;
      rd_wdata = 32'h0;
      test_reset();
      test_x0();
      test_basic();
      test_wen_gating();
      test_no_bypass();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile.md
# regfile

Integer register file for the RV32 core: 32 architectural registers of XLEN bits, two combinational read ports and one synchronous write port. It sits in the decode/execute path. It supplies rs1/rs2 operands and accepts the writeback result. x0 is hardwired to zero, and there is no internal write-to-read bypass; forwarding is the pipeline's job.

## Interface
Parameters:
- XLEN, default 32: data path width of every register and data port.

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- n_rst, input, 1: reset, asynchronous and active-high (asserted = 1); clears all registers.
- rs1_addr, input, REGISTER_INDEX_WIDTH (5): read port 1 register index.
- rs2_addr, input, REGISTER_INDEX_WIDTH (5): read port 2 register index.
- rd_addr, input, REGISTER_INDEX_WIDTH (5): write port destination index.
- rd_wen, input, 1: write enable, sampled at the clk rising edge.
- rd_wdata, input, XLEN: write data.
- rs1_data, output, XLEN: contents of register rs1_addr.
- rs2_data, output, XLEN: contents of register rs2_addr.

## Operation
- Storage: REGISTER_COUNT (32) entries × XLEN bits. Entry 0 (X0) always reads as zero.
- Write: at the clk rising edge, if rd_wen=1 and rd_addr≠0, then reg[rd_addr] ← rd_wdata.
  - If rd_wen=0, no register changes, regardless of rd_addr/rd_wdata.
  - A write to x0 is silently discarded. No error is reported and no state changes.
- Read: rsN_data = (rsN_addr==0) ? 0 : reg[rsN_addr].
  - Purely combinational and independent per port.
  - Both ports may address the same register at once.
- No write-through bypass. While a write to register R is pending in the current cycle, a read of R returns the old value. The new value is visible only after the rising edge.
- Reset: while n_rst=1, all 32 registers are forced to 0 immediately (asynchronous). Writes are ignored during reset.
- Outputs are never X/Z after reset for any address.

## Timing
- Read latency: 0 cycles (combinational from rsN_addr and register state).
- Write latency: 1 edge. Data written at edge k is readable combinationally right after edge k.
- Reset values: every register 0, so rs1_data = rs2_data = 0 for all addresses.
- Reset assertion mid-operation overrides any same-cycle write. After deassertion, the first rising edge with rd_wen=1 performs a normal write.
- Simultaneous read and write of the same register: the read shows the pre-edge value (see the bypass rule in Operation).
- Back-to-back writes to the same register on consecutive edges: last write wins.

## Structure
- The shared package riscv_pkg holds:
  - REGISTER_COUNT = 32
  - REGISTER_INDEX_WIDTH = $clog2(REGISTER_COUNT) = 5
  - X0 = 0 and other named register-index constants
  - XLEN default constant
- A single flat module is sufficient: register array, write-decode always_ff with asynchronous reset, and two combinational read muxes with the x0 guard.
- An optional sub-module regfile_read_port (index → data mux with zero-guard) may be instantiated twice.
- Storage is flip-flops (reset requires clearing every entry), not inferred RAM.

## Test plan
- Reset: assert n_rst for 2 cycles, then release. Read all 32 indices on both ports → every read = 0x00000000.
- x0 hardwired: write 0xFFFFFFFF to x0 with rd_wen=1, then read rs1=rs2=0 → both 0x00000000.
- Basic write/read: write x1=0x12345678 and x2=0xDEADBEEF, then set rs1=1, rs2=2 → rs1_data=0x12345678, rs2_data=0xDEADBEEF.
- Write-enable gating: rd_addr=3, rd_wdata=0x11111111, rd_wen=0 across an edge → x3 reads 0x00000000.
- No bypass:
  - Write x5=0xAAAA0001.
  - Next cycle, drive rd_addr=5, rd_wdata=0xBBBB0002, rd_wen=1 with rs1_addr=5 → before the edge, rs1_data=0xAAAA0001.
  - After the edge → rs1_data=0xBBBB0002.
- Random smoke: 200 iterations of random rd∈[1,31] and random data. Read back each on rs1 with rs2=0 → rs1_data matches the model, rs2_data=0. Also assert n_rst mid-sequence → all reads return 0 immediately.
